// File: rtl/timer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_ctrl_pkg
// Description : State encoding shared by the countdown timer controller.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_ctrl_pkg;

  localparam int c_STATE_W = 2;

  typedef enum logic [c_STATE_W-1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/countdown_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl_if
// Description : Control/status bundle between the host and the timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_ctrl_if
  import timer_ctrl_pkg::*;
#(
  parameter int SEC_W = 8
) ();

  logic                 start;
  logic                 pause;
  logic                 clear;
  logic [SEC_W-1:0]     load_val;
  logic [SEC_W-1:0]     remaining;
  logic [c_STATE_W-1:0] state;
  logic                 busy;
  logic                 sec_tick;
  logic                 expired;

  modport master (
    output start, pause, clear, load_val,
    input  remaining, state, busy, sec_tick, expired
  );

  modport slave (
    input  start, pause, clear, load_val,
    output remaining, state, busy, sec_tick, expired
  );

endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Enabled modulo-CRYSTAL_HZ counter with a terminal-count tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int PRESC_W    = 26,
  parameter int CRYSTAL_HZ = 50_000_000
) (
  input  wire logic CLK1,
  input  wire logic arst,
  input  wire logic en,
  input  wire logic clr,
  output logic      tick
);

  localparam logic [PRESC_W-1:0] c_TERM = PRESC_W'(CRYSTAL_HZ - 1);

  logic [PRESC_W-1:0] r_count;
  logic               w_at_term;

  assign w_at_term = (r_count == c_TERM);
  assign tick      = en & w_at_term;

  always_ff @(posedge CLK1) begin
    if (arst || clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= w_at_term ? '0 : r_count + PRESC_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : Start/pause/clear countdown timer with one-second prescaler.
//               Optional periodic reload enabled by TIMER_AUTO_RELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CRYSTAL_HZ = 50_000_000,
  parameter int PRESC_W    = 26,
  parameter int SEC_W      = 8
) (
  input  wire logic              CLK1,
  input  wire logic              arst,
  countdown_timer_ctrl_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEC_W-1:0] r_remaining;
  logic [SEC_W-1:0] w_remaining_nxt;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             w_presc_clr;
  logic             w_tick;
`ifdef TIMER_AUTO_RELOAD_EN
  logic [SEC_W-1:0] r_reload;
  logic [SEC_W-1:0] w_reload_nxt;
`endif

  tick_prescaler #(
    .PRESC_W    (PRESC_W),
    .CRYSTAL_HZ (CRYSTAL_HZ)
  ) u_presc (
    .CLK1 (CLK1),
    .arst (arst),
    .en   (r_state == RUN),
    .clr  (w_presc_clr),
    .tick (w_tick)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_expired_nxt   = 1'b0;
    w_presc_clr     = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
    w_reload_nxt    = r_reload;
`endif
    if (bus.clear) begin
      // clear outranks an expiry landing on the same edge
      w_state_nxt     = IDLE;
      w_remaining_nxt = '0;
      w_presc_clr     = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
      w_reload_nxt    = '0;
`endif
    end else begin
      case (r_state)
        IDLE, EXPIRED: begin
          if (bus.start && (bus.load_val != '0)) begin
            w_state_nxt     = RUN;
            w_remaining_nxt = bus.load_val;
            w_presc_clr     = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            w_reload_nxt    = bus.load_val;
`endif
          end
        end
        RUN: begin
          if (w_tick && (r_remaining <= SEC_W'(1))) begin
            w_expired_nxt   = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
            w_remaining_nxt = r_reload;
`else
            w_remaining_nxt = '0;
            w_state_nxt     = EXPIRED;
`endif
          end else begin
            if (w_tick) begin
              w_remaining_nxt = r_remaining - SEC_W'(1);
            end
            if (bus.pause) begin
              w_state_nxt = PAUSE;
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) begin
            w_state_nxt = RUN;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK1) begin
    if (arst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_expired   <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      r_reload    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_expired   <= w_expired_nxt;
`ifdef TIMER_AUTO_RELOAD_EN
      r_reload    <= w_reload_nxt;
`endif
    end
  end

  assign bus.state     = r_state;
  assign bus.remaining = r_remaining;
  assign bus.expired   = r_expired;
  assign bus.busy      = (r_state == RUN) || (r_state == PAUSE);
  assign bus.sec_tick  = w_tick;

endmodule
`default_nettype wire

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Countdown-timer controller that sequences a 1-second prescaler and a seconds down-counter under start/pause/clear control. It loads a seconds value, runs the prescaler only while counting, and holds the partial second across pauses. On expiry it raises a one-cycle `expired` pulse. It sits between user controls (debounced buttons or a host register) and display/alarm logic that consumes `remaining` and `expired`.

## Interface
- `CRYSTAL_HZ`, default 50_000_000: input clock frequency; one second = `CRYSTAL_HZ` cycles.
- `PRESC_W`, default 26: prescaler width; must satisfy 2^`PRESC_W` ≥ `CRYSTAL_HZ`.
- `SEC_W`, default 8: width of the seconds load value and of `remaining`.
- `CLK1`, in, 1: sole clock; all logic on the rising edge.
- `arst`, in, 1: reset, synchronous and active-high, sampled on the `CLK1` rising edge.
- `start`, in, 1: load `load_val` and begin counting; accepted only in IDLE or EXPIRED.
- `pause`, in, 1: level; while high, RUN moves to and stays in PAUSE.
- `clear`, in, 1: abort to IDLE.
- `load_val`, in, `SEC_W`: seconds to count; sampled on an accepted `start`.
- `remaining`, out, `SEC_W`: registered seconds left.
- `state`, out, 2: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.
- `busy`, out, 1: high in RUN or PAUSE.
- `sec_tick`, out, 1: combinational; high when `state`==RUN and prescaler==`CRYSTAL_HZ`-1.
- `expired`, out, 1: registered one-cycle pulse on terminal count.

## Operation
- Control priority per edge: `arst` > `clear` > `start` > `pause`.
- Reset values: `state`=IDLE, `remaining`=0, prescaler=0, `expired`=0, `busy`=0, `sec_tick`=0.
- IDLE or EXPIRED:
  - `start` with `load_val`≠0: go to RUN, `remaining`←`load_val`, prescaler←0.
  - `start` with `load_val`==0: ignored; state unchanged.
- RUN:
  - Prescaler increments each cycle and wraps to 0 after `CRYSTAL_HZ`-1; `sec_tick` is high during the wrap cycle.
  - On `sec_tick` with `remaining`>1: `remaining` decrements.
  - On `sec_tick` with `remaining`==1: `remaining`←0, state←EXPIRED, `expired`←1 for one cycle.
- `pause` high in RUN: next state PAUSE.
  - If `sec_tick` is high in that same cycle, the decrement or expiry still happens. Expiry wins over PAUSE.
- PAUSE:
  - Prescaler and `remaining` hold.
  - When `pause` is low, return to RUN, continuing from the held prescaler value.
- `start` in RUN or PAUSE: ignored. Restart requires `clear` then `start`, or expiry.
- `clear` in any state: state←IDLE, `remaining`←0, prescaler←0, `expired`←0. This holds even if expiry would occur that cycle.
- EXPIRED persists until `start` or `clear`.

## Timing
- Accepted `start` at edge k:
  - `state`=RUN and `remaining`=`load_val` are visible after edge k.
  - First `sec_tick` occurs in the cycle ending at edge k+`CRYSTAL_HZ`.
  - `expired`=1 and `remaining`=0 are visible after edge k+`load_val`·`CRYSTAL_HZ`; `expired` falls after the next edge.
- Each PAUSE cycle extends the expiry time by exactly one cycle.
- `remaining` never underflows; it wraps only by reload (see Configuration).
- `arst` or `clear` mid-run takes effect at that edge; no `expired` pulse follows.

## Configuration
- `TIMER_AUTO_RELOAD_EN` defined:
  - A `SEC_W` reload register captures `load_val` on each accepted `start`.
  - At terminal count: `remaining`←reload value, state stays RUN, `expired` still pulses, prescaler continues wrapping. This gives a periodic alarm.
  - `clear` zeroes the reload register.
- `TIMER_AUTO_RELOAD_EN` undefined: behaviour as in Operation; no reload register is present.

## Structure
- Package `timer_ctrl_pkg`: state encoding constants (IDLE/RUN/PAUSE/EXPIRED) and the state width constant 2.
- Sub-module `tick_prescaler`:
  - Parameters `PRESC_W`, `CRYSTAL_HZ`.
  - Inputs: `CLK1`, `arst`, `en`, `clr`.
  - Output: `tick`, asserted at count `CRYSTAL_HZ`-1 when `en` is high.
  - Synchronous clear; holds its count when `en` is low.
- The controller FSM, `remaining` register and `expired` register live in `countdown_timer_ctrl`.

## Test plan
All scenarios use `CRYSTAL_HZ`=4.
- Basic countdown: `load_val`=3, `start` at edge k → `sec_tick` at cycles ending k+4, k+8, k+12; `remaining` steps 3→2→1→0; `expired` high for exactly the one cycle after edge k+12; `state`=EXPIRED.
- Pause: `load_val`=2, `start`, `pause` high for 5 cycles starting 2 cycles in → `expired` after edge k+13; `remaining` holds during PAUSE.
- Edge controls:
  - `start` with `load_val`=0 → state stays IDLE.
  - `start` while RUN → ignored; `remaining` unchanged.
- Clear vs. expiry: `clear` asserted in the same cycle as the final `sec_tick` → IDLE, `remaining`=0, no `expired` pulse.
- Reset mid-run: `arst` after 6 cycles of RUN → all outputs at reset values after that edge; a subsequent `start` behaves as in the basic countdown.
- Auto-reload (with `TIMER_AUTO_RELOAD_EN`): `load_val`=2 → `expired` pulses after edges k+8 and k+16; `state` remains RUN; `remaining` reloads to 2.
